display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter WELCOME_FRAMES, default 180: number of frames the welcome banner is shown after reset.
REQ-002 Parameter BLINK_FRAMES, default 30: number of frames per half-period of the set-time highlight blink.
REQ-003 Parameter FRAME_HZ, default 60: number of frames per second, used to scale the feed duration.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 vsync  in  1  vertical-sync level; a rising edge marks a frame start.
REQ-007 state  in  6  system state; bit4 = set-time mode, bit5 = feeding request level.
REQ-008 dur  in  32  feed duration in seconds, sampled when FEED is entered.
REQ-009 req_a, req_b  in  1 each  sprite-ROM requests; A = character overlay, B = animation layer.
REQ-010 addr_a, addr_b  in  19 each  sprite-ROM addresses of requesters A and B.
REQ-011 rom_addr  out  19  registered address to the single-port sprite ROM.
REQ-012 gnt_a, gnt_b  out  1 each  registered one-hot grants.
REQ-013 mode  out  2  current screen: 0 WELCOME, 1 IDLE, 2 SETTIME, 3 FEED.
REQ-014 welcome_en, highlight_en, feed_en  out  1 each  layer enables to the display datapath.
REQ-015 frame_cnt  out  16  free-running frame counter.

Function
REQ-016 Frame tick = one-cycle pulse on the rising edge of vsync, detected with a registered previous-vsync; frame_cnt SHALL increment on each tick and wrap from 0xFFFF to 0.
REQ-017 FSM SHALL have exactly four states: WELCOME, IDLE, SETTIME, FEED; mode SHALL equal the state encoding.
REQ-018 WELCOME SHALL go to IDLE after WELCOME_FRAMES ticks; state inputs are ignored while in WELCOME.
REQ-019 IDLE SHALL go to FEED if state[5]=1, else to SETTIME if state[4]=1; FEED has priority when both bits are set.
REQ-020 SETTIME SHALL go to FEED if state[5]=1, else to IDLE if state[4]=0.
REQ-021 On FEED entry the frame budget SHALL be loaded as dur*FRAME_HZ, saturated to 2^24-1; each tick SHALL decrement it; FEED SHALL return to IDLE on the tick at which the budget reaches 0.
REQ-022 dur=0 on FEED entry SHALL return to IDLE on the next tick.
REQ-023 Changes to dur during FEED SHALL have no effect on the running budget.
REQ-024 welcome_en SHALL be 1 only in WELCOME.
REQ-025 feed_en SHALL be 1 only in FEED.
REQ-026 highlight_en SHALL be 1 only in SETTIME and only during the "on" half-period.
REQ-027 The blink phase SHALL start "on" at SETTIME entry and toggle every BLINK_FRAMES ticks.
REQ-028 All mode and enable outputs SHALL be registered and SHALL change on the clock edge after the tick or the input change that causes them.
REQ-029 Arbiter: when exactly one req is high, that requester SHALL be granted.
REQ-030 Arbiter: when both req are high, the grant SHALL be round-robin, starting with the requester not granted last; after reset A is first.
REQ-031 Arbiter: when neither req is high, both grants SHALL be 0 and rom_addr SHALL hold its value.
REQ-032 Arbiter latency: gnt_x and rom_addr SHALL reflect the request and address sampled on the previous edge (1 cycle).
REQ-033 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-034 During WELCOME, requester B SHALL be masked: req_b is treated as 0.

Reset
REQ-035 While reset=0: mode=WELCOME, all enables=0, frame_cnt=0, gnt_a=gnt_b=0, rom_addr=0, feed budget=0, blink phase "on", round-robin pointer set to favour A.
REQ-036 Reset assertion mid-operation (for example during FEED) SHALL force the reset values immediately, without waiting for a clock edge.
REQ-037 After release, the welcome count SHALL restart from 0.

Verification
REQ-038 Reset release with WELCOME_FRAMES=3: after the 3rd vsync rising edge, mode goes 0->1 and welcome_en goes 1->0 on the next clock edge.
REQ-039 In IDLE, set state[5]=1 and state[4]=1 with dur=2, FRAME_HZ=4: mode goes to 3, feed_en=1 for exactly 8 ticks, then mode=1.
REQ-040 In SETTIME with BLINK_FRAMES=2: highlight_en sequence per tick is 1,1,0,0,1,1; clearing state[4] gives mode=1 and highlight_en=0.
REQ-041 req_a=req_b=1 held for 4 cycles, addr_a=0x00010, addr_b=0x00020 -> grants alternate A,B,A,B; rom_addr alternates 0x00010,0x00020 with 1-cycle lag; gnt_a&gnt_b is never 1.
REQ-042 Assert reset low mid-FEED between clock edges -> outputs reach the reset values before the next edge; after release, mode=0 and frame_cnt=0.
REQ-043 In WELCOME with req_b=1 and req_a=0 -> gnt_b stays 0; after the move to IDLE, gnt_b=1 one cycle later.

Source files
------------

// File: rtl/display_scheduler.sv
// Display scheduler: frame-tick driven screen FSM (welcome/idle/set-time/feed)
// with layer enables, plus a two-requester round-robin sprite-ROM arbiter.
module display_scheduler #(
    parameter int WELCOME_FRAMES = 180,
    parameter int BLINK_FRAMES   = 30,
    parameter int FRAME_HZ       = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic [5:0]  state,
    input  logic [31:0] dur,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [18:0] addr_a,
    input  logic [18:0] addr_b,
    output logic [18:0] rom_addr,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [1:0]  mode,
    output logic        welcome_en,
    output logic        highlight_en,
    output logic        feed_en,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_WELCOME = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SETTIME = 2'd2,
        ST_FEED    = 2'd3
    } fsm_e;

    localparam logic [63:0] BUDGET_MAX = 64'h0000_0000_00FF_FFFF;

    // Frame budget for a feed: dur seconds at FRAME_HZ, clamped to 24 bits.
    function automatic logic [23:0] feed_budget(input logic [31:0] d);
        logic [63:0] p;
        p = {32'd0, d} * 64'(FRAME_HZ);
        if (p > BUDGET_MAX) begin
            return 24'hFF_FFFF;
        end else begin
            return p[23:0];
        end
    endfunction

    logic        vsync_q;
    logic        tick_s;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    fsm_e        fsm_q, fsm_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic [23:0] budget_q, budget_d;
    logic        blink_on_q, blink_on_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        welcome_en_q, welcome_en_d;
    logic        highlight_en_q, highlight_en_d;
    logic        feed_en_q, feed_en_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic [18:0] rom_addr_q, rom_addr_d;
    logic        rr_b_q, rr_b_d;
    logic        req_b_m_s;
    logic        unused_state_bits_s;

    assign unused_state_bits_s = &{1'b0, state[3:0]};
    assign tick_s    = vsync & ~vsync_q;
    assign req_b_m_s = req_b & (fsm_q != ST_WELCOME);

    // Screen FSM next state, welcome/blink counters and feed budget.
    always_comb begin
        fsm_d       = fsm_q;
        wcnt_d      = wcnt_q;
        budget_d    = budget_q;
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q;
        frame_cnt_d = tick_s ? frame_cnt_q + 16'd1 : frame_cnt_q;
        case (fsm_q)
            ST_WELCOME: begin
                if (tick_s) begin
                    if (wcnt_q + 32'd1 >= 32'(WELCOME_FRAMES)) begin
                        fsm_d  = ST_IDLE;
                        wcnt_d = 32'd0;
                    end else begin
                        wcnt_d = wcnt_q + 32'd1;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            ST_IDLE: begin
                if (state[5]) begin
                    fsm_d    = ST_FEED;
                    budget_d = feed_budget(dur);
                end else if (state[4]) begin
                    fsm_d       = ST_SETTIME;
                    blink_on_d  = 1'b1;
                    blink_cnt_d = 32'd0;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_SETTIME: begin
                if (state[5]) begin
                    fsm_d    = ST_FEED;
                    budget_d = feed_budget(dur);
                end else if (!state[4]) begin
                    fsm_d = ST_IDLE;
                end else if (tick_s) begin
                    if (blink_cnt_q + 32'd1 >= 32'(BLINK_FRAMES)) begin
                        blink_on_d  = ~blink_on_q;
                        blink_cnt_d = 32'd0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 32'd1;
                    end
                end else begin
                    blink_cnt_d = blink_cnt_q;
                end
            end
            ST_FEED: begin
                // A budget of 0 or 1 is exhausted by this tick.
                if (tick_s) begin
                    if (budget_q <= 24'd1) begin
                        fsm_d    = ST_IDLE;
                        budget_d = 24'd0;
                    end else begin
                        budget_d = budget_q - 24'd1;
                    end
                end else begin
                    budget_d = budget_q;
                end
            end
            default: begin
                fsm_d = ST_WELCOME;
            end
        endcase
        welcome_en_d   = (fsm_d == ST_WELCOME);
        feed_en_d      = (fsm_d == ST_FEED);
        highlight_en_d = (fsm_d == ST_SETTIME) && blink_on_d;
    end

    // Round-robin arbitration; the pointer favours whoever was not granted last.
    always_comb begin
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rom_addr_d = rom_addr_q;
        rr_b_d     = rr_b_q;
        if (req_a && (!req_b_m_s || !rr_b_q)) begin
            gnt_a_d    = 1'b1;
            rom_addr_d = addr_a;
            rr_b_d     = 1'b1;
        end else if (req_b_m_s) begin
            gnt_b_d    = 1'b1;
            rom_addr_d = addr_b;
            rr_b_d     = 1'b0;
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q        <= 1'b0;
            frame_cnt_q    <= 16'd0;
            fsm_q          <= ST_WELCOME;
            wcnt_q         <= 32'd0;
            budget_q       <= 24'd0;
            blink_on_q     <= 1'b1;
            blink_cnt_q    <= 32'd0;
            welcome_en_q   <= 1'b0;
            highlight_en_q <= 1'b0;
            feed_en_q      <= 1'b0;
            gnt_a_q        <= 1'b0;
            gnt_b_q        <= 1'b0;
            rom_addr_q     <= 19'd0;
            rr_b_q         <= 1'b0;
        end else begin
            vsync_q        <= vsync;
            frame_cnt_q    <= frame_cnt_d;
            fsm_q          <= fsm_d;
            wcnt_q         <= wcnt_d;
            budget_q       <= budget_d;
            blink_on_q     <= blink_on_d;
            blink_cnt_q    <= blink_cnt_d;
            welcome_en_q   <= welcome_en_d;
            highlight_en_q <= highlight_en_d;
            feed_en_q      <= feed_en_d;
            gnt_a_q        <= gnt_a_d;
            gnt_b_q        <= gnt_b_d;
            rom_addr_q     <= rom_addr_d;
            rr_b_q         <= rr_b_d;
        end
    end

    assign mode         = fsm_q;
    assign welcome_en   = welcome_en_q;
    assign highlight_en = highlight_en_q;
    assign feed_en      = feed_en_q;
    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign rom_addr     = rom_addr_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios plus random
// stimulus, all compared against a behavioural model updated once per clock.
module tb_display_scheduler;

    localparam int WF = 3;
    localparam int BF = 2;
    localparam int FH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic [5:0]  state;
    logic [31:0] dur;
    logic        req_a, req_b;
    logic [18:0] addr_a, addr_b;
    logic [18:0] rom_addr;
    logic        gnt_a, gnt_b;
    logic [1:0]  mode;
    logic        welcome_en, highlight_en, feed_en;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_mode, m_wticks, m_blink_ticks, m_frame;
    longint      m_budget;
    bit          m_prev_vsync, m_last_b, m_ga, m_gb, m_we, m_he, m_fe;
    logic [18:0] m_rom;

    display_scheduler #(.WELCOME_FRAMES(WF), .BLINK_FRAMES(BF), .FRAME_HZ(FH)) dut (
        .clk(clk), .reset(reset_n), .vsync(vsync), .state(state), .dur(dur),
        .req_a(req_a), .req_b(req_b), .addr_a(addr_a), .addr_b(addr_b),
        .rom_addr(rom_addr), .gnt_a(gnt_a), .gnt_b(gnt_b), .mode(mode),
        .welcome_en(welcome_en), .highlight_en(highlight_en), .feed_en(feed_en),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wticks = 0; m_blink_ticks = 0; m_frame = 0; m_budget = 0;
        m_prev_vsync = 1'b0; m_last_b = 1'b1; m_ga = 1'b0; m_gb = 1'b0;
        m_we = 1'b0; m_he = 1'b0; m_fe = 1'b0; m_rom = '0;
    endtask

    function automatic longint load_budget(input logic [31:0] d);
        longint unsigned p;
        p = longint'({32'd0, d}) * FH;
        return (p > 64'd16777215) ? 64'd16777215 : longint'(p);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit tick, eff_b;
        int nm;
        tick = vsync && !m_prev_vsync;
        m_prev_vsync = vsync;
        eff_b = req_b && (m_mode != 0);
        m_ga = 1'b0; m_gb = 1'b0;
        if (req_a && (!eff_b || m_last_b)) begin
            m_ga = 1'b1; m_rom = addr_a; m_last_b = 1'b0;
        end else if (eff_b) begin
            m_gb = 1'b1; m_rom = addr_b; m_last_b = 1'b1;
        end
        if (tick) m_frame = (m_frame + 1) % 65536;
        nm = m_mode;
        case (m_mode)
            0: if (tick) begin
                m_wticks++;
                if (m_wticks >= WF) nm = 1;
            end
            1: if (state[5]) begin
                nm = 3; m_budget = load_budget(dur);
            end else if (state[4]) begin
                nm = 2; m_blink_ticks = 0;
            end
            2: if (state[5]) begin
                nm = 3; m_budget = load_budget(dur);
            end else if (!state[4]) begin
                nm = 1;
            end else if (tick) begin
                m_blink_ticks++;
            end
            default: if (tick) begin
                if (m_budget > 0) m_budget--;
                if (m_budget == 0) nm = 1;
            end
        endcase
        m_mode = nm;
        m_we = (nm == 0);
        m_fe = (nm == 3);
        m_he = (nm == 2) && (((m_blink_ticks / BF) % 2) == 0);
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".mode"}, 32'(mode), 32'(m_mode));
        check_eq({tag, ".welcome_en"}, 32'(welcome_en), 32'(m_we));
        check_eq({tag, ".highlight_en"}, 32'(highlight_en), 32'(m_he));
        check_eq({tag, ".feed_en"}, 32'(feed_en), 32'(m_fe));
        check_eq({tag, ".gnt_a"}, 32'(gnt_a), 32'(m_ga));
        check_eq({tag, ".gnt_b"}, 32'(gnt_b), 32'(m_gb));
        check_eq({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_rom));
        check_eq({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_frame));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".mode"}, 32'(mode), 32'd0);
        check_eq({tag, ".en"}, {29'd0, welcome_en, highlight_en, feed_en}, 32'd0);
        check_eq({tag, ".gnt"}, {30'd0, gnt_a, gnt_b}, 32'd0);
        check_eq({tag, ".rom_addr"}, 32'(rom_addr), 32'd0);
        check_eq({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic frame(input string tag);
        vsync = 1'b1;
        cycle(tag);
        vsync = 1'b0;
        cycle(tag);
    endtask

    initial begin
        reset_n = 1'b0; vsync = 1'b0; state = 6'd0; dur = 32'd0;
        req_a = 1'b0; req_b = 1'b0; addr_a = 19'h1234; addr_b = 19'h4321;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");

        // Welcome screen with B requesting: B stays masked until IDLE.
        #3 reset_n = 1'b1;
        req_b = 1'b1;
        cycle("welcome");
        check_eq("welcome_en_on", 32'(welcome_en), 32'd1);
        frame("welcome");
        frame("welcome");
        check_eq("welcome_mode_hold", 32'(mode), 32'd0);
        check_eq("welcome_gnt_b_masked", 32'(gnt_b), 32'd0);
        vsync = 1'b1;
        cycle("welcome_exit");
        check_eq("welcome_exit_mode", 32'(mode), 32'd1);
        check_eq("welcome_exit_en", 32'(welcome_en), 32'd0);
        check_eq("welcome_exit_gnt_b", 32'(gnt_b), 32'd0);
        vsync = 1'b0;
        cycle("idle_b");
        check_eq("idle_gnt_b", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        cycle("idle");

        // Feed with both bits set, dur=2 -> 8 ticks; dur changes are ignored.
        state = 6'h30; dur = 32'd2;
        cycle("feed_entry");
        check_eq("feed_entry_mode", 32'(mode), 32'd3);
        state = 6'h00; dur = 32'd7;
        for (int i = 1; i <= 8; i++) begin
            frame("feed");
            check_eq("feed_en_run", 32'(feed_en), (i < 8) ? 32'd1 : 32'd0);
        end
        check_eq("feed_exit_mode", 32'(mode), 32'd1);

        // Zero duration leaves on the next tick.
        state = 6'h20; dur = 32'd0;
        cycle("feed0_entry");
        state = 6'h00;
        frame("feed0");
        check_eq("feed0_exit_mode", 32'(mode), 32'd1);

        // Set-time blink: 1 at entry, then 1,0,0,1,1 per tick.
        state = 6'h10;
        cycle("settime_entry");
        check_eq("settime_hl_entry", 32'(highlight_en), 32'd1);
        for (int i = 0; i < 5; i++) begin
            frame("settime");
            check_eq("settime_hl", 32'(highlight_en), (i == 1 || i == 2) ? 32'd0 : 32'd1);
        end
        state = 6'h00;
        cycle("settime_exit");
        check_eq("settime_exit_mode", 32'(mode), 32'd1);
        check_eq("settime_exit_hl", 32'(highlight_en), 32'd0);

        // Both requesters held: A,B,A,B.
        req_a = 1'b1; req_b = 1'b1; addr_a = 19'h00010; addr_b = 19'h00020;
        for (int i = 0; i < 4; i++) begin
            cycle("rr");
            check_eq("rr_gnt_a", 32'(gnt_a), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_addr", 32'(rom_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
            check_eq("rr_onehot", 32'(gnt_a & gnt_b), 32'd0);
        end
        req_a = 1'b0; req_b = 1'b0;
        cycle("rr_idle");
        check_eq("rr_hold_addr", 32'(rom_addr), 32'h20);

        // Large duration saturates instead of wrapping to a zero budget.
        state = 6'h20; dur = 32'h0040_0000;
        cycle("sat_entry");
        state = 6'h00;
        repeat (3) frame("sat");
        check_eq("sat_still_feed", 32'(mode), 32'd3);

        // Asynchronous reset in the middle of FEED, between clock edges.
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        #3 reset_n = 1'b1;
        cycle("post_rst");
        check_eq("post_rst_mode", 32'(mode), 32'd0);
        check_eq("post_rst_frame", 32'(frame_cnt), 32'd0);

        // Random operation against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) vsync = ~vsync;
            if ($urandom_range(0, 9) == 0) begin
                state = 6'($urandom);
                state[5] = ($urandom_range(0, 5) == 0);
            end
            dur = 32'($urandom_range(0, 3));
            req_a = 1'($urandom);
            req_b = 1'($urandom);
            addr_a = 19'($urandom);
            addr_b = 19'($urandom);
            cycle("rand");
            if (gnt_a && gnt_b) check_eq("rand_onehot", 32'd1, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
